// File: rtl/conv_column_feeder_if.sv
// Pixel-stream in / column-stream out bundle for conv_column_feeder.
// Master is the pixel source, slave is the feeder.
interface conv_column_feeder_if #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 16
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [PIX_W-1:0]   pix_in;
  logic               pix_valid;
  logic               sof;
  logic [3*PIX_W-1:0] col_out;
  logic               col_valid;
  logic               pool_sel;
  logic [CW-1:0]      col_idx;
  logic [RW-1:0]      row_idx;
  logic               frame_done;

  modport master (
    output pix_in, pix_valid, sof,
    input  col_out, col_valid, pool_sel,
    input  col_idx, row_idx, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output col_out, col_valid, pool_sel,
    output col_idx, row_idx, frame_done
  );
endinterface

// File: rtl/conv_column_feeder.sv
// Raster pixel stream to 3-row vertical columns.
// Two line buffers hold rows r-1 and r-2.
module conv_column_feeder #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = 16
) (
  input logic clk,
  input logic rst,
  conv_column_feeder_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] R_TWO  = RW'(2);

  logic [CW-1:0] c, c_cur, c_nxt;
  logic [RW-1:0] r, r_cur, r_nxt;
  logic          c_wrap;
  logic          primed;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  // Effective position: sof forces (0,0) for its pixel.
  always_comb begin
    c_cur  = bus.sof ? '0 : c;
    r_cur  = bus.sof ? '0 : r;
    c_wrap = (c_cur == C_LAST);
    c_nxt  = c_wrap ? '0 : c_cur + 1'b1;
    r_nxt  = r_cur;
    if (c_wrap)
      r_nxt = (r_cur == R_LAST) ? '0 : r_cur + 1'b1;
    primed = (r_cur >= R_TWO);
    lb0_rd = lb0[c_cur];
    lb1_rd = lb1[c_cur];
  end

  // Position counters advance on every accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
      r <= '0;
    end else if (bus.pix_valid) begin
      c <= c_nxt;
      r <= r_nxt;
    end
  end

  // Line buffers shift down one row per column; not reset.
  always_ff @(posedge clk) begin
    if (bus.pix_valid) begin
      lb1[c_cur] <= lb0_rd;
      lb0[c_cur] <= bus.pix_in;
    end
  end

  // Column register; data holds across gaps, strobes drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.col_out    <= '0;
      bus.col_valid  <= 1'b0;
      bus.pool_sel   <= 1'b0;
      bus.col_idx    <= '0;
      bus.row_idx    <= '0;
      bus.frame_done <= 1'b0;
    end else if (bus.pix_valid) begin
      bus.col_out    <= {lb1_rd, lb0_rd, bus.pix_in};
      bus.col_valid  <= primed;
      bus.pool_sel   <= primed & c_cur[0];
      bus.col_idx    <= c_cur;
      bus.row_idx    <= r_cur;
      bus.frame_done <= (r_cur == R_LAST) & c_wrap;
    end else begin
      bus.col_valid  <= 1'b0;
      bus.pool_sel   <= 1'b0;
      bus.frame_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_column_feeder.sv
// Directed bench for conv_column_feeder, 4x4 frames.
// Pixel value = base + 16*r + c.
module tb_conv_column_feeder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  conv_column_feeder_if #(
    .IMG_W(4), .IMG_H(4), .PIX_W(16)
  ) bus ();

  conv_column_feeder #(
    .IMG_W(4), .IMG_H(4), .PIX_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [15:0] v, input logic s);
    bus.pix_in    = v;
    bus.pix_valid = 1'b1;
    bus.sof       = s;
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
  endtask

  task automatic idle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.pix_in = '0;
    bus.pix_valid = 1'b0;
    bus.sof = 1'b0;
    #1 rst = 1'b1;
    #12;
    tests++;
    if (bus.col_out !== 48'h0 || bus.col_valid !== 1'b0
        || bus.pool_sel !== 1'b0 || bus.col_idx !== 2'd0
        || bus.row_idx !== 2'd0 || bus.frame_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: col_out=%h v=%b p=%b c=%0d r=%0d fd=%b want all 0",
               bus.col_out, bus.col_valid, bus.pool_sel,
               bus.col_idx, bus.row_idx, bus.frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  task automatic test_frame;
    logic [15:0] a, b, d;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        drive(16'(16*r + c), (r == 0 && c == 0));
        if (r < 2) begin
          tests++;
          if (bus.col_valid !== 1'b0) begin
            fails++;
            $display("FAIL prime_valid(%0d,%0d): got %b want 0",
                     r, c, bus.col_valid);
          end
        end else begin
          a = 16'(16*(r-2) + c);
          b = 16'(16*(r-1) + c);
          d = 16'(16*r + c);
          tests++;
          if (bus.col_out !== {a, b, d} || bus.col_valid !== 1'b1
              || bus.pool_sel !== (c % 2 == 1)
              || bus.col_idx !== 2'(c) || bus.row_idx !== 2'(r)
              || bus.frame_done !== (r == 3 && c == 3)) begin
            fails++;
            $display("FAIL col(%0d,%0d): got %h v%b p%b c%0d r%0d fd%b want %h",
                     r, c, bus.col_out, bus.col_valid, bus.pool_sel,
                     bus.col_idx, bus.row_idx, bus.frame_done, {a, b, d});
          end
        end
        if (r == 2 && c == 0) begin
          tests++;
          if (bus.col_out !== 48'h0000_0010_0020 || bus.pool_sel !== 1'b0) begin
            fails++;
            $display("FAIL first_col: got %h p%b want 000000100020 p0",
                     bus.col_out, bus.pool_sel);
          end
        end
        if (r == 2 && c == 1) begin
          tests++;
          if (bus.col_out !== 48'h0001_0011_0021 || bus.pool_sel !== 1'b1) begin
            fails++;
            $display("FAIL pool_pair: got %h p%b want 000100110021 p1",
                     bus.col_out, bus.pool_sel);
          end
        end
        if (r == 3 && c == 3) begin
          tests++;
          if (bus.col_out !== 48'h0013_0023_0033 || bus.frame_done !== 1'b1) begin
            fails++;
            $display("FAIL last_col: got %h fd%b want 001300230033 fd1",
                     bus.col_out, bus.frame_done);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, b, d;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        drive(16'(256 + 16*r + c), 1'b0);
        if (r == 0 && c == 0) begin
          tests++;
          if (bus.frame_done !== 1'b0) begin
            fails++;
            $display("FAIL frame_done_pulse: got %b want 0", bus.frame_done);
          end
        end
        if (r < 2) begin
          tests++;
          if (bus.col_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_prime(%0d,%0d): got %b want 0",
                     r, c, bus.col_valid);
          end
        end else begin
          a = 16'(256 + c);
          b = 16'(256 + 16 + c);
          d = 16'(256 + 32 + c);
          tests++;
          if (bus.col_out !== {a, b, d} || bus.col_valid !== 1'b1
              || bus.row_idx !== 2'd2 || bus.col_idx !== 2'(c)) begin
            fails++;
            $display("FAIL b2b_col(2,%0d): got %h v%b r%0d c%0d want %h",
                     c, bus.col_out, bus.col_valid,
                     bus.row_idx, bus.col_idx, {a, b, d});
          end
        end
      end
    end
  endtask

  task automatic test_gap;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        drive(16'(16*r + c), (r == 0 && c == 0));
    drive(16'h0020, 1'b0);
    drive(16'h0021, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      tests++;
      if (bus.col_valid !== 1'b0 || bus.pool_sel !== 1'b0
          || bus.frame_done !== 1'b0 || bus.col_out !== 48'h0001_0011_0021
          || bus.col_idx !== 2'd1 || bus.row_idx !== 2'd2) begin
        fails++;
        $display("FAIL gap_hold[%0d]: got %h v%b p%b fd%b c%0d r%0d want 000100110021 strobes 0",
                 i, bus.col_out, bus.col_valid, bus.pool_sel,
                 bus.frame_done, bus.col_idx, bus.row_idx);
      end
    end
    drive(16'h0022, 1'b0);
    tests++;
    if (bus.col_out !== 48'h0002_0012_0022 || bus.col_valid !== 1'b1
        || bus.pool_sel !== 1'b0 || bus.col_idx !== 2'd2) begin
      fails++;
      $display("FAIL gap_resume: got %h v%b p%b c%0d want 000200120022 v1 p0 c2",
               bus.col_out, bus.col_valid, bus.pool_sel, bus.col_idx);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] a, b, d;
    drive(16'h0023, 1'b0);
    drive(16'h0030, 1'b0);
    drive(16'h0031, 1'b0);
    tests++;
    if (bus.col_out !== 48'h0011_0021_0031 || bus.col_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got %h v%b want 001100210031 v1",
               bus.col_out, bus.col_valid);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.col_out !== 48'h0 || bus.col_valid !== 1'b0
        || bus.pool_sel !== 1'b0 || bus.col_idx !== 2'd0
        || bus.row_idx !== 2'd0 || bus.frame_done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got %h v%b p%b c%0d r%0d fd%b want all 0",
               bus.col_out, bus.col_valid, bus.pool_sel,
               bus.col_idx, bus.row_idx, bus.frame_done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        drive(16'(512 + 16*r + c), (r == 0 && c == 0));
        if (r < 2) begin
          tests++;
          if (bus.col_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_rst_prime(%0d,%0d): got %b want 0",
                     r, c, bus.col_valid);
          end
        end else begin
          a = 16'(512 + c);
          b = 16'(512 + 16 + c);
          d = 16'(512 + 32 + c);
          tests++;
          if (bus.col_out !== {a, b, d} || bus.col_valid !== 1'b1) begin
            fails++;
            $display("FAIL post_rst_col(2,%0d): got %h v%b want %h v1",
                     c, bus.col_out, bus.col_valid, {a, b, d});
          end
        end
      end
    end
  endtask

  task automatic test_sof_resync;
    int n;
    for (int c = 0; c < 4; c++)
      drive(16'(16*c), (c == 0));
    drive(16'h0010, 1'b0);
    drive(16'h0011, 1'b0);
    n = 0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        drive(16'(768 + 16*r + c), (r == 0 && c == 0));
        n++;
        tests++;
        if (bus.col_valid !== 1'b0) begin
          fails++;
          $display("FAIL sof_prime[%0d]: got %b want 0", n, bus.col_valid);
        end
      end
    end
    drive(16'h0320, 1'b0);
    tests++;
    if (bus.col_valid !== 1'b1 || bus.row_idx !== 2'd2
        || bus.col_idx !== 2'd0 || bus.col_out !== 48'h0300_0310_0320) begin
      fails++;
      $display("FAIL sof_first_col: got %h v%b r%0d c%0d want 030003100320 v1 r2 c0",
               bus.col_out, bus.col_valid, bus.row_idx, bus.col_idx);
    end
    bus.sof = 1'b1;
    idle();
    bus.sof = 1'b0;
    drive(16'h0321, 1'b0);
    tests++;
    if (bus.col_idx !== 2'd1 || bus.row_idx !== 2'd2
        || bus.col_out !== 48'h0301_0311_0321) begin
      fails++;
      $display("FAIL sof_no_valid: got %h r%0d c%0d want 030103110321 r2 c1",
               bus.col_out, bus.row_idx, bus.col_idx);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_sof_resync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
